seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Sequential controller for the 4-digit multiplexed 7-segment display.
- Accepts a 14-bit binary value over a valid/ready handshake.
- Converts it to 4 BCD digits iteratively (shift-add-3, one bit per clock) and holds the result in a display register.
- Time-multiplexes the digits onto the shared segment bus with a prescaled scan counter.
- Sits between the value source (switches/counter logic) and the board's segment/common pins. Replaces the combinational divider chain and scan decode.

Parameters:
PRESCALE, 50000, clocks per digit slot; must be >= 2.
CLAMP_VAL, 9999, displayed value when input exceeds 9999.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
in14  in  14  binary value to display
in_valid  in  1  in14 is valid this cycle
in_ready  out  1  controller can accept a value (high only in IDLE)
ovf  out  1  last accepted value exceeded 9999
busy  out  1  conversion in progress (CONV or DONE)
out4_scan  out  4  digit commons, active-low one-cold; bit n = digit n (bit0 = units)
out7_seg  out  7  segments a..g on bits 0..6, active-low

Behaviour:
- Reset values (all take effect on the edge with rst=1):
  - state=IDLE, in_ready=1, busy=0, ovf=0
  - display BCD register=0000
  - scan index=0, prescaler=0
  - out4_scan=4'b1110, out7_seg=7'b1000000 (digit '0')
- FSM states: IDLE, CONV, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready at edge E0:
    - capture in14 into the shift register; if in14>9999, capture CLAMP_VAL instead and set ovf_pending=1.
    - clear the 16-bit working BCD; iteration counter=0; go to CONV.
  - CONV: 14 cycles. Each cycle:
    - add 3 to every working BCD nibble >=5;
    - then shift {bcd,bin} left by 1.
    - After the 14th shift (counter==13), go to DONE.
  - DONE: one cycle. Copy working BCD into the display register; ovf<=ovf_pending; go to IDLE.
- Latency:
  - accept at edge E0; new digits and ovf are visible after edge E0+15;
  - in_ready returns high in that same cycle;
  - in_ready is low for exactly 15 cycles.
- Inputs presented while not ready are ignored; no queueing.
- The display register keeps showing the previous value throughout conversion, so there is no glitch on the outputs.
- Scan:
  - prescaler counts 0..PRESCALE-1 and wraps;
  - on wrap, scan index increments 0→1→2→3→0;
  - scan runs continuously, independent of FSM state;
  - out4_scan = ~(4'b0001<<idx) unless blanked (see optional feature).
- Segment decode (active-low) from the selected BCD nibble:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibbles 10-15 (unreachable) give 1111111
- Outputs are registered: out4_scan and out7_seg update together one cycle after the index/register change, with no skew between them.
- Reset mid-conversion: conversion is abandoned and everything returns to reset values; no partial result reaches the display.
- rst has priority over in_valid in the same cycle.

Optional Feature:
SEG7_LZB_EN — leading-zero blanking.
- Defined: a digit n>0 is blanked (out4_scan=4'b1111, out7_seg=7'b1111111 during its slot) when it and all higher digits are 0. Digit 0 is never blanked. Blanking is decided from the display register, not the working register.
- Undefined: all four digits are always driven, so leading zeros show as '0'.

Test Plan:
- Reset, PRESCALE=4 -> out4_scan=1110, out7_seg=1000000, in_ready=1, ovf=0; after 4 clocks out4_scan=1101. With LZB: 1111 with segments 1111111.
- Load 1234 at E0 -> in_ready low for E0+1..E0+15, busy high; after E0+15 the slots show 4,3,2,1 on units..thousands (0011001, 0110000, 0100100, 1111001).
- Load 16383 -> ovf=1 after E0+15, digits show 9999. Then load 7 -> ovf=0, display 0007; with LZB only digit 0 is lit, showing 1111000.
- Pulse in_valid with 5555 during CONV of 42 -> ignored; the display becomes 0042 and is never 5555.
- Assert rst at E0+7 mid-conversion of 8888 -> next cycle display 0000, in_ready=1, scan index=0, ovf=0.
- Load 0 and 9999 back-to-back, asserting in_valid the first cycle in_ready rises -> the second value is accepted at that edge; the display moves 0000→9999 with no intermediate values.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - binary-to-BCD converting, prescaled 4-digit 7-segment scan controller
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
  parameter int PRESCALE  = 50000,
  parameter int CLAMP_VAL = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] in14,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ovf,
  output logic        busy,
  output logic [3:0]  out4_scan,
  output logic [6:0]  out7_seg
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e        state_q, state_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [14:0]   bcd_adj;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    scan_q, scan_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nib;
  logic          blank;
  logic          accept;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (cnt_q == 4'd13) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  assign accept = in_valid & in_ready;

  // Thousands nibble never reaches 5 mid-conversion because inputs are clamped to 9999.
  always_comb begin
    bcd_adj = bcd_q[14:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in14 > 14'd9999) begin
            bin_d      = 14'(CLAMP_VAL);
            ovf_pend_d = 1'b1;
          end else begin
            bin_d      = in14;
            ovf_pend_d = 1'b0;
          end
          bcd_d = '0;
          cnt_d = '0;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
      end
      DONE: begin
        disp_d = bcd_q;
        ovf_d  = ovf_pend_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PW'(PRESCALE - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  assign nib = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
  always_comb begin
    case (idx_q)
      2'd1:    blank = (disp_q[15:4] == 12'd0);
      2'd2:    blank = (disp_q[15:8] == 8'd0);
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    scan_d = ~(4'b0001 << idx_q);
    case (nib)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
    if (blank) begin
      scan_d = 4'b1111;
      seg_d  = 7'b1111111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      pre_q      <= '0;
      idx_q      <= '0;
      scan_q     <= 4'b1110;
      seg_q      <= 7'b1000000;
    end else begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      scan_q     <= scan_d;
      seg_q      <= seg_d;
    end
  end

  assign ovf       = ovf_q;
  assign out4_scan = scan_q;
  assign out7_seg  = seg_q;
endmodule
